// File: rtl/bm_arb_pkg.sv
// bm_arb_pkg: shared definitions for the bus-matrix output-port arbiter.
//   - arb_state_t : arbiter FSM state encoding
//   - HTRANS_*    : AHB transfer-type encodings used by the input stages
//   - onehot2bin  : one-hot (up to 8 bits) to binary index
package bm_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN  = 2'd1,
        ARB_LOCK = 2'd2
    } arb_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Callers zero-extend their vector to 8 bits and truncate the result.
    function automatic logic [31:0] onehot2bin(input logic [7:0] oh);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) b = b | 32'(i);
        end
        return b;
    endfunction

endpackage

// File: rtl/bm_rr_select.sv
// bm_rr_select: combinational masked-priority picker.
//   req  [NUM_MASTERS] : request vector
//   ptr  [ID_W]        : index of the last winner; search starts at ptr+1
//   gnt  [NUM_MASTERS] : one-hot winner, all-zero when req is all-zero
module bm_rr_select #(
    parameter int NUM_MASTERS = 3,
    parameter int ID_W        = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [ID_W-1:0]        ptr,
    output logic [NUM_MASTERS-1:0] gnt
);

    logic [NUM_MASTERS-1:0] mask;
    logic [NUM_MASTERS-1:0] masked;
    logic                   found;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            mask[i] = (ID_W'(i) > ptr);
        end
        masked = req & mask;
    end

    // Lowest set bit above the pointer wins; otherwise wrap to the lowest
    // set bit of the whole request vector.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (masked[i] && !found) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (req[i] && !found) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_dma_output_arbiter.sv
// ahb_dma_output_arbiter: arbitrates one bus-matrix output port between
// NUM_MASTERS input stages, holding ownership through bursts and locks.
//   HCLK, HRESETn : clock, async active-low reset
//   HREADYM       : output-port HREADY; all state advances only when high
//   REQ/SEQ/LOCK  : per-master request, burst-continue, HMASTLOCK
//   ADDR_SEL      : one-hot address-phase owner (0 = no port)
//   DATA_SEL      : one-hot data-phase owner (0 = idle data phase)
//   ADDR_ID       : binary index of ADDR_SEL owner
//   NO_PORT       : ADDR_SEL is all-zero
//   MASTLOCK      : owner is holding a locked sequence
// Build option BM_ARB_ROUND_ROBIN_EN: round-robin selection when defined,
// fixed lowest-index priority (no pointer register) otherwise.
//
// state    | meaning
// ---------+-------------------------------
// ARB_IDLE | no owner
// ARB_OWN  | owner, unlocked
// ARB_LOCK | owner holding a locked sequence
module ahb_dma_output_arbiter
    import bm_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int ID_W        = 2
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   HREADYM,
    input  logic [NUM_MASTERS-1:0] REQ,
    input  logic [NUM_MASTERS-1:0] SEQ,
    input  logic [NUM_MASTERS-1:0] LOCK,
    output logic [NUM_MASTERS-1:0] ADDR_SEL,
    output logic [NUM_MASTERS-1:0] DATA_SEL,
    output logic [ID_W-1:0]        ADDR_ID,
    output logic                   NO_PORT,
    output logic                   MASTLOCK
);

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] addr_sel_q, addr_sel_d;
    logic [NUM_MASTERS-1:0] data_sel_q;
    logic [NUM_MASTERS-1:0] winner;
    logic [ID_W-1:0]        ptr;
    logic                   own_seq, own_lock, win_lock, rearb;

`ifdef BM_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    // Pointer pinned to the last index: search always starts at master 0.
    assign ptr = ID_W'(NUM_MASTERS - 1);
`endif

    bm_rr_select #(
        .NUM_MASTERS (NUM_MASTERS),
        .ID_W        (ID_W)
    ) u_select (
        .req (REQ),
        .ptr (ptr),
        .gnt (winner)
    );

    assign own_seq  = |(addr_sel_q & SEQ);
    assign own_lock = |(addr_sel_q & LOCK);
    assign win_lock = |(winner & LOCK);

    always_comb begin
        state_d    = state_q;
        addr_sel_d = addr_sel_q;
        rearb      = 1'b0;
        case (state_q)
            ARB_IDLE: rearb = 1'b1;
            ARB_OWN:  rearb = !own_seq;
            ARB_LOCK: rearb = !(own_lock || own_seq);
            default:  rearb = 1'b1;
        endcase
        if (rearb) begin
            addr_sel_d = winner;
            if (|REQ) state_d = win_lock ? ARB_LOCK : ARB_OWN;
            else      state_d = ARB_IDLE;
        end
    end

`ifdef BM_ARB_ROUND_ROBIN_EN
    always_comb begin
        ptr_d = ptr_q;
        if (rearb && |REQ) ptr_d = ID_W'(onehot2bin(8'(winner)));
    end
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ARB_IDLE;
            addr_sel_q <= '0;
            data_sel_q <= '0;
`ifdef BM_ARB_ROUND_ROBIN_EN
            ptr_q      <= ID_W'(NUM_MASTERS - 1);
`endif
        end else if (HREADYM) begin
            state_q    <= state_d;
            addr_sel_q <= addr_sel_d;
            // Owner that stopped requesting leaves an idle data phase.
            data_sel_q <= addr_sel_q & REQ;
`ifdef BM_ARB_ROUND_ROBIN_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign ADDR_SEL = addr_sel_q;
    assign DATA_SEL = data_sel_q;
    assign ADDR_ID  = ID_W'(onehot2bin(8'(addr_sel_q)));
    assign NO_PORT  = ~|addr_sel_q;
    assign MASTLOCK = (state_q == ARB_LOCK);

endmodule

// File: tb/tb_ahb_dma_output_arbiter.sv
module tb_ahb_dma_output_arbiter;

    localparam int N    = 3;
    localparam int ID_W = 2;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          HREADYM = 1'b1;
    logic [N-1:0]  REQ = '0, SEQ = '0, LOCK = '0;
    logic [N-1:0]  ADDR_SEL, DATA_SEL;
    logic [ID_W-1:0] ADDR_ID;
    logic          NO_PORT, MASTLOCK;

    int n_chk = 0;
    int n_err = 0;

    // reference model: owner indices as integers, -1 = none
    int m_owner  = -1;
    int m_data   = -1;
    int m_ptr    = N - 1;
    bit m_locked = 1'b0;

    ahb_dma_output_arbiter #(.NUM_MASTERS(N), .ID_W(ID_W)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HREADYM  (HREADYM),
        .REQ      (REQ),
        .SEQ      (SEQ),
        .LOCK     (LOCK),
        .ADDR_SEL (ADDR_SEL),
        .DATA_SEL (DATA_SEL),
        .ADDR_ID  (ADDR_ID),
        .NO_PORT  (NO_PORT),
        .MASTLOCK (MASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sel_of(input int idx);
        return (idx >= 0) ? (32'd1 << idx) : 32'd0;
    endfunction

    function automatic int pick(input logic [N-1:0] req);
`ifdef BM_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
`else
        for (int k = 0; k < N; k++) begin
            if (req[k]) return k;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_data = -1; m_ptr = N - 1; m_locked = 1'b0;
    endtask

    task automatic model_edge();
        int  w;
        bit  hold;
        m_data = (m_owner >= 0 && REQ[m_owner]) ? m_owner : -1;
        hold = (m_owner >= 0) && (SEQ[m_owner] || (m_locked && LOCK[m_owner]));
        if (!hold) begin
            w = pick(REQ);
            m_owner  = w;
            m_locked = (w >= 0) && LOCK[w];
            if (w >= 0) m_ptr = w;
        end
    endtask

    task automatic compare_all();
        check("addr_sel", 32'(ADDR_SEL), sel_of(m_owner));
        check("data_sel", 32'(DATA_SEL), sel_of(m_data));
        check("addr_id",  32'(ADDR_ID),  (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check("no_port",  32'(NO_PORT),  32'(m_owner < 0));
        check("mastlock", 32'(MASTLOCK), 32'(m_locked));
        check("onehot0",  32'($onehot0(ADDR_SEL)), 32'd1);
    endtask

    task automatic step(input logic [N-1:0] req, input logic [N-1:0] seq,
                        input logic [N-1:0] lock, input logic rdy);
        REQ = req; SEQ = seq; LOCK = lock; HREADYM = rdy;
        @(posedge HCLK);
        if (HRESETn && rdy) model_edge();
        #1;
        compare_all();
    endtask

    // async reset asserted mid-cycle, held for two edges with REQ=101
    task automatic do_reset();
        #2;
        HRESETn = 1'b0;
        #1;
        model_reset();
        compare_all();
        step(3'b101, 3'b000, 3'b000, 1'b1);
        step(3'b101, 3'b000, 3'b000, 1'b1);
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    logic [N-1:0] rr_exp [4];

    initial begin
        do_reset();

        // first grant after reset, then its data phase
        step(3'b101, 3'b000, 3'b000, 1'b1);
        check("rst_first_addr", 32'(ADDR_SEL), 32'b001);
        check("rst_first_id",   32'(ADDR_ID),  32'd0);
        step(3'b101, 3'b000, 3'b000, 1'b1);
        check("rst_first_data", 32'(DATA_SEL), 32'b001);

        // 4-beat burst from master0 with master2 waiting
        do_reset();
        step(3'b101, 3'b000, 3'b000, 1'b1);
        check("burst_b1", 32'(ADDR_SEL), 32'b001);
        for (int b = 2; b <= 4; b++) begin
            step(3'b101, 3'b001, 3'b000, 1'b1);
            check("burst_hold", 32'(ADDR_SEL), 32'b001);
        end
        step(3'b100, 3'b000, 3'b000, 1'b1);
        check("burst_next", 32'(ADDR_SEL), 32'b100);

        // wait states freeze everything
        do_reset();
        step(3'b001, 3'b000, 3'b000, 1'b1);
        step(3'b001, 3'b000, 3'b000, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(3'b110, 3'b000, 3'b000, 1'b0);
            check("wait_addr", 32'(ADDR_SEL), 32'b001);
            check("wait_data", 32'(DATA_SEL), 32'b001);
        end
        step(3'b110, 3'b000, 3'b000, 1'b1);
        check("wait_rearb", 32'(ADDR_SEL), 32'b010);
        check("wait_data_idle", 32'(DATA_SEL), 32'b000);

        // all requesting with single transfers
        do_reset();
`ifdef BM_ARB_ROUND_ROBIN_EN
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
`else
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b001; rr_exp[2] = 3'b001; rr_exp[3] = 3'b001;
`endif
        for (int c = 0; c < 4; c++) begin
            step(3'b111, 3'b000, 3'b000, 1'b1);
            check("rr_seq", 32'(ADDR_SEL), 32'(rr_exp[c]));
        end

        // locked sequence from master1 while master0 waits
        do_reset();
        step(3'b010, 3'b000, 3'b010, 1'b1);
        check("lock_grant", 32'(ADDR_SEL), 32'b010);
        check("lock_ml", 32'(MASTLOCK), 32'd1);
        step(3'b011, 3'b000, 3'b010, 1'b1);
        check("lock_hold", 32'(ADDR_SEL), 32'b010);
        check("lock_ml2", 32'(MASTLOCK), 32'd1);
        step(3'b011, 3'b000, 3'b000, 1'b1);
        check("lock_release", 32'(ADDR_SEL), 32'b001);
        check("lock_ml_off", 32'(MASTLOCK), 32'd0);

        // everyone drops requests
        step(3'b000, 3'b000, 3'b000, 1'b1);
        check("drop_addr", 32'(ADDR_SEL), 32'b000);
        check("drop_noport", 32'(NO_PORT), 32'd1);
        step(3'b000, 3'b000, 3'b000, 1'b1);
        check("drop_data", 32'(DATA_SEL), 32'b000);

        // reset in the middle of a locked burst
        step(3'b111, 3'b100, 3'b010, 1'b1);
        step(3'b111, 3'b111, 3'b010, 1'b1);
        do_reset();
        check("midrst_addr", 32'(ADDR_SEL), 32'b000);

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] r, s, l;
            logic         rdy;
            r   = N'($urandom_range(0, (1 << N) - 1));
            s   = N'($urandom_range(0, (1 << N) - 1)) & r & N'($urandom_range(0, (1 << N) - 1));
            l   = ($urandom_range(0, 3) == 0) ? (N'($urandom_range(0, (1 << N) - 1)) & r) : '0;
            rdy = ($urandom_range(0, 4) != 0);
            step(r, s, l, rdy);
            if (c == 200) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
